// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - value input and scanned display signals of seg_scan_driver
interface seg_scan_driver_if;
  logic        en;
  logic [23:0] data_in;
  logic [5:0]  dp_in;
  logic        data_vld;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        frame_tick;

  modport master (
    output en, data_in, dp_in, data_vld,
    input  sel, seg, frame_tick
  );

  modport slave (
    input  en, data_in, dp_in, data_vld,
    output sel, seg, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - six-digit multiplexed seven-segment scanner, frame-synchronous value update
module seg_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int GAP      = 500,
  parameter int BLANK_LZ = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  seg_scan_driver_if.slave   bus
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div;
  logic [2:0]    idx;
  logic [23:0]   shadow_data;
  logic [5:0]    shadow_dp;
  logic [23:0]   disp_data;
  logic [5:0]    disp_dp;
  logic          pending;

  logic          slot_end;
  logic          wrap;
  logic          load;
  logic          in_gap;
  logic [3:0]    nib;
  logic          upper_zero;
  logic          blank;
  logic [6:0]    hex;
  logic [5:0]    sel_nx;
  logic [7:0]    seg_nx;

  assign slot_end = bus.en && (div == DW'(SCAN_DIV - 1));
  assign wrap     = slot_end && (idx == 3'd5);
  // A disabled display has no frame to protect, so the pending value goes in at once.
  assign load     = pending && (wrap || !bus.en);
  assign in_gap   = div < DW'(GAP);

  always_comb begin
    nib        = disp_data[{idx, 2'b00} +: 4];
    upper_zero = (disp_data >> {idx, 2'b00}) == 24'd0;
    blank      = (BLANK_LZ != 0) && (idx != 3'd0) && upper_zero;
    case (nib)
      4'h0:    hex = 7'h40;
      4'h1:    hex = 7'h79;
      4'h2:    hex = 7'h24;
      4'h3:    hex = 7'h30;
      4'h4:    hex = 7'h19;
      4'h5:    hex = 7'h12;
      4'h6:    hex = 7'h02;
      4'h7:    hex = 7'h78;
      4'h8:    hex = 7'h00;
      4'h9:    hex = 7'h10;
      4'hA:    hex = 7'h08;
      4'hB:    hex = 7'h03;
      4'hC:    hex = 7'h46;
      4'hD:    hex = 7'h21;
      4'hE:    hex = 7'h06;
      default: hex = 7'h0E;
    endcase
    sel_nx = ~(6'b000001 << idx);
    seg_nx = {~disp_dp[idx], blank ? 7'h7F : hex};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div            <= '0;
      idx            <= 3'd0;
      shadow_data    <= 24'd0;
      shadow_dp      <= 6'd0;
      disp_data      <= 24'd0;
      disp_dp        <= 6'd0;
      pending        <= 1'b0;
      bus.sel        <= 6'h3F;
      bus.seg        <= 8'hFF;
      bus.frame_tick <= 1'b0;
    end else begin
      if (load) begin
        disp_data <= shadow_data;
        disp_dp   <= shadow_dp;
      end
      // A strobe coinciding with a load keeps pending set for the newer value.
      if (bus.data_vld) begin
        shadow_data <= bus.data_in;
        shadow_dp   <= bus.dp_in;
        pending     <= 1'b1;
      end else if (load) begin
        pending <= 1'b0;
      end

      if (!bus.en) begin
        div            <= '0;
        idx            <= 3'd0;
        bus.sel        <= 6'h3F;
        bus.seg        <= 8'hFF;
        bus.frame_tick <= 1'b0;
      end else begin
        if (slot_end) begin
          div <= '0;
          idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
          div <= div + DW'(1);
        end
        bus.frame_tick <= wrap;
        if (in_gap) begin
          bus.sel <= 6'h3F;
          bus.seg <= 8'hFF;
        end else begin
          bus.sel <= sel_nx;
          bus.seg <= seg_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed bench for seg_scan_driver with SCAN_DIV=10, GAP=2
module tb_seg_scan_driver;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;

  logic [7:0] fseg [6];
  logic [5:0] fsel [6];
  logic [7:0] fnb  [6];
  logic [5:0] gap_sel;
  logic       ft59;
  logic       ft60;

  seg_scan_driver_if bus ();
  seg_scan_driver_if bus_nb ();

  seg_scan_driver #(.SCAN_DIV(10), .GAP(2), .BLANK_LZ(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  seg_scan_driver #(.SCAN_DIV(10), .GAP(2), .BLANK_LZ(0)) dut_nb (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_nb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic v, input logic [23:0] d, input logic [5:0] p);
    bus.en          = e;
    bus.data_vld    = v;
    bus.data_in     = d;
    bus.dp_in       = p;
    bus_nb.en       = e;
    bus_nb.data_vld = v;
    bus_nb.data_in  = d;
    bus_nb.dp_in    = p;
  endtask

  // Starts one cycle after a frame_tick and records one whole frame; strobes land on edges s1/s2.
  task automatic capture_frame(input int s1, input logic [23:0] d1, input logic [5:0] p1,
                               input int s2, input logic [23:0] d2, input logic [5:0] p2);
    for (int c = 1; c <= 60; c++) begin
      if (c == s1)      drive(1'b1, 1'b1, d1, p1);
      else if (c == s2) drive(1'b1, 1'b1, d2, p2);
      else              drive(1'b1, 1'b0, 24'd0, 6'd0);
      step();
      if (c == 1) gap_sel = bus.sel;
      if (c >= 3 && ((c - 3) % 10) == 0) begin
        fseg[(c - 3) / 10] = bus.seg;
        fsel[(c - 3) / 10] = bus.sel;
        fnb[(c - 3) / 10]  = bus_nb.seg;
      end
      if (c == 59) ft59 = bus.frame_tick;
      if (c == 60) ft60 = bus.frame_tick;
    end
    drive(1'b1, 1'b0, 24'd0, 6'd0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 24'd0, 6'd0);
    step();
    step();
    n_total++; if (bus.sel !== 6'h3F) $display("FAIL reset_sel: got %h expected 3f", bus.sel); else n_pass++;
    n_total++; if (bus.seg !== 8'hFF) $display("FAIL reset_seg: got %h expected ff", bus.seg); else n_pass++;
    n_total++; if (bus.frame_tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", bus.frame_tick); else n_pass++;
    reset_n = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 1 || c == 2) begin
        n_total++; if (bus.sel !== 6'h3F) $display("FAIL start_gap_sel c%0d: got %h expected 3f", c, bus.sel); else n_pass++;
      end
      if (c == 3) begin
        n_total++; if (bus.sel !== 6'h3E) $display("FAIL start_d0_sel: got %h expected 3e", bus.sel); else n_pass++;
        n_total++; if (bus.seg !== 8'hC0) $display("FAIL start_d0_seg: got %h expected c0", bus.seg); else n_pass++;
      end
      if (c == 13) begin
        n_total++; if (bus.sel !== 6'h3D) $display("FAIL start_d1_sel: got %h expected 3d", bus.sel); else n_pass++;
        n_total++; if (bus.seg !== 8'hFF) $display("FAIL start_d1_blank: got %h expected ff", bus.seg); else n_pass++;
      end
      if (c == 59) begin
        n_total++; if (bus.frame_tick !== 1'b0) $display("FAIL start_tick59: got %b expected 0", bus.frame_tick); else n_pass++;
      end
      if (c == 60) begin
        n_total++; if (bus.frame_tick !== 1'b1) $display("FAIL start_tick60: got %b expected 1", bus.frame_tick); else n_pass++;
      end
    end
  endtask

  task automatic test_idle_frame();
    logic [7:0] exp [6];
    logic [5:0] es;
    exp = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    capture_frame(0, 24'd0, 6'd0, 0, 24'd0, 6'd0);
    n_total++; if (gap_sel !== 6'h3F) $display("FAIL idle_gap_sel: got %h expected 3f", gap_sel); else n_pass++;
    n_total++; if (ft59 !== 1'b0) $display("FAIL idle_tick59: got %b expected 0", ft59); else n_pass++;
    n_total++; if (ft60 !== 1'b1) $display("FAIL idle_tick60: got %b expected 1", ft60); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      es = ~(6'b000001 << i);
      n_total++; if (fsel[i] !== es) $display("FAIL idle_sel d%0d: got %h expected %h", i, fsel[i], es); else n_pass++;
      n_total++; if (fseg[i] !== exp[i]) $display("FAIL idle_seg d%0d: got %h expected %h", i, fseg[i], exp[i]); else n_pass++;
      n_total++; if (fnb[i] !== 8'hC0) $display("FAIL nolz_seg d%0d: got %h expected c0", i, fnb[i]); else n_pass++;
    end
  endtask

  task automatic test_update();
    logic [7:0] old_exp [6];
    logic [7:0] exp [6];
    old_exp = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp     = '{8'h8E, 8'hC0, 8'h03, 8'h88, 8'hA4, 8'hF9};
    capture_frame(15, 24'h12AB0F, 6'b000100, 0, 24'd0, 6'd0);
    for (int i = 0; i < 6; i++) begin
      n_total++; if (fseg[i] !== old_exp[i]) $display("FAIL update_hold d%0d: got %h expected %h", i, fseg[i], old_exp[i]); else n_pass++;
    end
    capture_frame(0, 24'd0, 6'd0, 0, 24'd0, 6'd0);
    for (int i = 0; i < 6; i++) begin
      n_total++; if (fseg[i] !== exp[i]) $display("FAIL update_new d%0d: got %h expected %h", i, fseg[i], exp[i]); else n_pass++;
      n_total++; if (fnb[i] !== exp[i]) $display("FAIL update_nolz d%0d: got %h expected %h", i, fnb[i], exp[i]); else n_pass++;
    end
  endtask

  task automatic test_last_wins();
    logic [7:0] prev [6];
    logic [7:0] exp [6];
    prev = '{8'h8E, 8'hC0, 8'h03, 8'h88, 8'hA4, 8'hF9};
    exp  = '{8'hA4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    capture_frame(12, 24'h000001, 6'd0, 25, 24'h000002, 6'd0);
    for (int i = 0; i < 6; i++) begin
      n_total++; if (fseg[i] !== prev[i]) $display("FAIL lastwins_hold d%0d: got %h expected %h", i, fseg[i], prev[i]); else n_pass++;
    end
    capture_frame(0, 24'd0, 6'd0, 0, 24'd0, 6'd0);
    for (int i = 0; i < 6; i++) begin
      n_total++; if (fseg[i] !== exp[i]) $display("FAIL lastwins_new d%0d: got %h expected %h", i, fseg[i], exp[i]); else n_pass++;
    end
  endtask

  task automatic test_wrap_collision();
    capture_frame(30, 24'h000003, 6'd0, 60, 24'h000004, 6'd0);
    n_total++; if (fseg[0] !== 8'hA4) $display("FAIL wrap_hold d0: got %h expected a4", fseg[0]); else n_pass++;
    capture_frame(0, 24'd0, 6'd0, 0, 24'd0, 6'd0);
    n_total++; if (fseg[0] !== 8'hB0) $display("FAIL wrap_first d0: got %h expected b0", fseg[0]); else n_pass++;
    n_total++; if (fseg[1] !== 8'hFF) $display("FAIL wrap_first d1: got %h expected ff", fseg[1]); else n_pass++;
    capture_frame(0, 24'd0, 6'd0, 0, 24'd0, 6'd0);
    n_total++; if (fseg[0] !== 8'h99) $display("FAIL wrap_second d0: got %h expected 99", fseg[0]); else n_pass++;
    n_total++; if (ft60 !== 1'b1) $display("FAIL wrap_tick60: got %b expected 1", ft60); else n_pass++;
  endtask

  task automatic test_en_drop();
    for (int c = 1; c <= 35; c++) step();
    n_total++; if (bus.sel !== 6'h37) $display("FAIL endrop_d3_sel: got %h expected 37", bus.sel); else n_pass++;
    drive(1'b0, 1'b0, 24'd0, 6'd0);
    step();
    n_total++; if (bus.sel !== 6'h3F) $display("FAIL endrop_sel: got %h expected 3f", bus.sel); else n_pass++;
    n_total++; if (bus.seg !== 8'hFF) $display("FAIL endrop_seg: got %h expected ff", bus.seg); else n_pass++;
    n_total++; if (bus.frame_tick !== 1'b0) $display("FAIL endrop_tick: got %b expected 0", bus.frame_tick); else n_pass++;
    drive(1'b0, 1'b1, 24'h000005, 6'd0);
    step();
    drive(1'b0, 1'b0, 24'd0, 6'd0);
    step();
    step();
    n_total++; if (bus.sel !== 6'h3F) $display("FAIL endrop_hold_sel: got %h expected 3f", bus.sel); else n_pass++;
    drive(1'b1, 1'b0, 24'd0, 6'd0);
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 1 || c == 2) begin
        n_total++; if (bus.sel !== 6'h3F) $display("FAIL reen_gap c%0d: got %h expected 3f", c, bus.sel); else n_pass++;
      end
      if (c == 3) begin
        n_total++; if (bus.sel !== 6'h3E) $display("FAIL reen_d0_sel: got %h expected 3e", bus.sel); else n_pass++;
        n_total++; if (bus.seg !== 8'h92) $display("FAIL reen_d0_seg: got %h expected 92", bus.seg); else n_pass++;
      end
      if (c == 60) begin
        n_total++; if (bus.frame_tick !== 1'b1) $display("FAIL reen_tick60: got %b expected 1", bus.frame_tick); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 1; c <= 20; c++) begin
      if (c == 5) drive(1'b1, 1'b1, 24'h000007, 6'b000001);
      else        drive(1'b1, 1'b0, 24'd0, 6'd0);
      step();
    end
    n_total++; if (bus.sel !== 6'h3D) $display("FAIL rstmid_pre_sel: got %h expected 3d", bus.sel); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++; if (bus.sel !== 6'h3F) $display("FAIL rstmid_async_sel: got %h expected 3f", bus.sel); else n_pass++;
    n_total++; if (bus.seg !== 8'hFF) $display("FAIL rstmid_async_seg: got %h expected ff", bus.seg); else n_pass++;
    step();
    step();
    reset_n = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 3) begin
        n_total++; if (bus.sel !== 6'h3E) $display("FAIL rstmid_d0_sel: got %h expected 3e", bus.sel); else n_pass++;
        n_total++; if (bus.seg !== 8'hC0) $display("FAIL rstmid_d0_seg: got %h expected c0", bus.seg); else n_pass++;
      end
      if (c == 60) begin
        n_total++; if (bus.frame_tick !== 1'b1) $display("FAIL rstmid_tick60: got %b expected 1", bus.frame_tick); else n_pass++;
      end
    end
    capture_frame(0, 24'd0, 6'd0, 0, 24'd0, 6'd0);
    n_total++; if (fseg[0] !== 8'hC0) $display("FAIL rstmid_discard d0: got %h expected c0", fseg[0]); else n_pass++;
    n_total++; if (fseg[1] !== 8'hFF) $display("FAIL rstmid_discard d1: got %h expected ff", fseg[1]); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_idle_frame();
    test_update();
    test_last_wins();
    test_wrap_collision();
    test_en_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
